// File: rtl/pipelined_control_unit_if.sv
// -----------------------------------------------------------------------------
// pipelined_control_unit_if
// Groups the decode-side handshake and the ID/EX control bundle of
// pipelined_control_unit into one interface.
//   slave  : the control unit (consumes instruction fields and stall/flush,
//            drives id_ready, md_busy and the registered bundle)
//   master : the surrounding pipeline (fetch/decode and execute stages)
// Signals:
//   in_valid, op[6:0], funct3[2:0], funct7[6:0]  decode-stage instruction
//   ex_stall, flush                              execute-stage back-pressure/kill
//   id_ready                                     instruction accepted this cycle
//   ex_valid + control bits                      registered ID/EX bundle
//   md_busy                                      multi-cycle M op in progress
// -----------------------------------------------------------------------------
interface pipelined_control_unit_if;
  logic       in_valid;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       ex_stall;
  logic       flush;
  logic       id_ready;
  logic       ex_valid;
  logic       RegWrite;
  logic       MemWrite;
  logic       ALUSrc;
  logic       LoadSign;
  logic       Jump;
  logic       JumpReg;
  logic       Branch;
  logic       Illegal;
  logic [1:0] ResultSrc;
  logic [2:0] ImmSrc;
  logic [1:0] SizeSrc;
  logic [2:0] BranchType;
  logic [4:0] ALUControl;
  logic       md_busy;

  modport slave (
    input  in_valid, op, funct3, funct7, ex_stall, flush,
    output id_ready, ex_valid, RegWrite, MemWrite, ALUSrc, LoadSign, Jump,
           JumpReg, Branch, Illegal, ResultSrc, ImmSrc, SizeSrc, BranchType,
           ALUControl, md_busy
  );

  modport master (
    output in_valid, op, funct3, funct7, ex_stall, flush,
    input  id_ready, ex_valid, RegWrite, MemWrite, ALUSrc, LoadSign, Jump,
           JumpReg, Branch, Illegal, ResultSrc, ImmSrc, SizeSrc, BranchType,
           ALUControl, md_busy
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// -----------------------------------------------------------------------------
// pipelined_control_unit
// RV32I instruction decoder with an ID/EX pipeline register. Decodes
// op/funct3/funct7 into the execute-stage control bundle, holds it under
// ex_stall, kills it on flush and parks multi-cycle multiply/divide ops in a
// WAIT state until their latency has elapsed.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active-low
//   cu     pipelined_control_unit_if.slave (handshake + registered bundle)
// Parameters:
//   MUL_CYCLES  execute latency of MUL/MULH/MULHSU/MULHU (1..255)
//   DIV_CYCLES  execute latency of DIV/DIVU/REM/REMU (1..255)
// Build option:
//   RV32M_EN  when defined, M ops decode and use the WAIT state; otherwise
//             funct7=0000001 on an R-type opcode decodes as Illegal.
// -----------------------------------------------------------------------------
module pipelined_control_unit #(
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  pipelined_control_unit_if.slave        cu
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       load_sign;
    logic       jump;
    logic       jump_reg;
    logic       branch;
    logic       illegal;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [1:0] size_src;
    logic [2:0] branch_type;
    logic [4:0] alu_control;
  } ctl_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_M      = 7'b0000001;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLTU = 5'b00101;
  localparam logic [4:0] ALU_SLT  = 5'b00110;
  localparam logic [4:0] ALU_PASS = 5'b00111;
  localparam logic [4:0] ALU_SLL  = 5'b01000;
  localparam logic [4:0] ALU_SRL  = 5'b01001;
  localparam logic [4:0] ALU_SRA  = 5'b01010;
  localparam logic [4:0] ALU_ILL  = 5'b01111;

  if (MUL_CYCLES < 1 || MUL_CYCLES > 255 || DIV_CYCLES < 1 || DIV_CYCLES > 255) begin : g_bad_latency
    $error("pipelined_control_unit: MUL_CYCLES/DIV_CYCLES must be in 1..255");
  end

  // ALU op from funct3; alt (funct7[5]) picks SUB only for R-type, SRA for both.
  function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt, input logic is_reg);
    logic [4:0] r;
    case (f3)
      3'b000:  r = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      3'b111:  r = ALU_AND;
      default: r = ALU_ILL;
    endcase
    return r;
  endfunction

  function automatic ctl_t illegal_ctl();
    ctl_t c;
    c             = '0;
    c.illegal     = 1'b1;
    c.imm_src     = 3'b111;
    c.alu_control = ALU_ILL;
    return c;
  endfunction

  ctl_t dec_s;
  ctl_t out_r;
  ctl_t out_nx_s;
  logic valid_r;
  logic valid_nx_s;
  logic id_ready_s;

`ifdef RV32M_EN
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  localparam logic [7:0] MUL_N = 8'(MUL_CYCLES);
  localparam logic [7:0] DIV_N = 8'(DIV_CYCLES);

  state_t     state_r;
  state_t     state_nx_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nx_s;
  ctl_t       held_r;
  ctl_t       held_nx_s;
  logic       is_m_s;
  logic [7:0] m_lat_s;

  assign m_lat_s = cu.funct3[2] ? DIV_N : MUL_N;
`endif

  // Instruction-field decode into a control bundle.
  always_comb begin
    dec_s = '0;
`ifdef RV32M_EN
    is_m_s = 1'b0;
`endif
    case (cu.op)
      OP_R: begin
        if (cu.funct7 == F7_M) begin
`ifdef RV32M_EN
          is_m_s            = 1'b1;
          dec_s.reg_write   = 1'b1;
          dec_s.alu_control = {2'b10, cu.funct3};
`else
          dec_s = illegal_ctl();
`endif
        end else begin
          dec_s.reg_write   = 1'b1;
          dec_s.alu_control = alu_op(cu.funct3, cu.funct7[5], 1'b1);
        end
      end
      OP_I: begin
        dec_s.reg_write   = 1'b1;
        dec_s.alu_src     = 1'b1;
        dec_s.alu_control = alu_op(cu.funct3, cu.funct7[5], 1'b0);
        // Shift-immediates take a 5-bit shamt instead of the I immediate.
        dec_s.imm_src     = (cu.funct3[1:0] == 2'b01) ? 3'b101 : 3'b000;
      end
      OP_LOAD: begin
        dec_s.reg_write  = 1'b1;
        dec_s.alu_src    = 1'b1;
        dec_s.result_src = 2'b01;
        case (cu.funct3)
          3'b000:  begin dec_s.size_src = 2'b10; dec_s.load_sign = 1'b1; end
          3'b001:  begin dec_s.size_src = 2'b01; dec_s.load_sign = 1'b1; end
          3'b010:  begin dec_s.size_src = 2'b00; dec_s.load_sign = 1'b1; end
          3'b100:  begin dec_s.size_src = 2'b10; dec_s.load_sign = 1'b0; end
          3'b101:  begin dec_s.size_src = 2'b01; dec_s.load_sign = 1'b0; end
          default: begin dec_s.size_src = 2'b00; dec_s.load_sign = 1'b0; end
        endcase
      end
      OP_STORE: begin
        dec_s.mem_write = 1'b1;
        dec_s.alu_src   = 1'b1;
        dec_s.imm_src   = 3'b001;
        case (cu.funct3)
          3'b000:  dec_s.size_src = 2'b10;
          3'b001:  dec_s.size_src = 2'b01;
          default: dec_s.size_src = 2'b00;
        endcase
      end
      OP_BRANCH: begin
        dec_s.branch      = 1'b1;
        dec_s.imm_src     = 3'b010;
        dec_s.branch_type = cu.funct3;
        dec_s.alu_control = ALU_SUB;
      end
      OP_JAL: begin
        dec_s.reg_write  = 1'b1;
        dec_s.jump       = 1'b1;
        dec_s.result_src = 2'b10;
        dec_s.imm_src    = 3'b011;
      end
      OP_JALR: begin
        dec_s.reg_write  = 1'b1;
        dec_s.jump_reg   = 1'b1;
        dec_s.alu_src    = 1'b1;
        dec_s.result_src = 2'b10;
      end
      OP_LUI: begin
        dec_s.reg_write   = 1'b1;
        dec_s.alu_src     = 1'b1;
        dec_s.imm_src     = 3'b100;
        dec_s.alu_control = ALU_PASS;
      end
      OP_AUIPC: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src   = 1'b1;
        dec_s.imm_src   = 3'b100;
      end
      default: dec_s = illegal_ctl();
    endcase
  end

  // Next-state, next-bundle and handshake logic; flush overrides everything.
  always_comb begin
    valid_nx_s = valid_r;
    out_nx_s   = out_r;
    id_ready_s = 1'b0;
`ifdef RV32M_EN
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    held_nx_s  = held_r;
`endif
    if (cu.flush) begin
      valid_nx_s = 1'b0;
      out_nx_s   = '0;
`ifdef RV32M_EN
      state_nx_s = ST_IDLE;
      cnt_nx_s   = 8'd0;
`endif
`ifdef RV32M_EN
    end else if (state_r == ST_WAIT) begin
      // The counter runs regardless of ex_stall; only the release waits for it.
      if (cnt_r != 8'd0) begin
        cnt_nx_s = cnt_r - 8'd1;
      end else if (!cu.ex_stall) begin
        valid_nx_s = 1'b1;
        out_nx_s   = held_r;
        state_nx_s = ST_IDLE;
      end else begin
        cnt_nx_s = 8'd0;
      end
`endif
    end else if (cu.ex_stall) begin
      valid_nx_s = valid_r;
    end else begin
      id_ready_s = 1'b1;
      if (cu.in_valid) begin
`ifdef RV32M_EN
        if (is_m_s && (m_lat_s != 8'd1)) begin
          valid_nx_s = 1'b0;
          out_nx_s   = '0;
          held_nx_s  = dec_s;
          cnt_nx_s   = m_lat_s - 8'd1;
          state_nx_s = ST_WAIT;
        end else begin
          valid_nx_s = 1'b1;
          out_nx_s   = dec_s;
        end
`else
        valid_nx_s = 1'b1;
        out_nx_s   = dec_s;
`endif
      end else begin
        valid_nx_s = 1'b0;
        out_nx_s   = '0;
      end
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      out_r   <= '0;
    end else begin
      valid_r <= valid_nx_s;
      out_r   <= out_nx_s;
    end
  end

`ifdef RV32M_EN
  // Multi-cycle FSM state, latency counter and the parked M-op bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      held_r  <= '0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      held_r  <= held_nx_s;
    end
  end

  assign cu.md_busy = (state_r == ST_WAIT);
`else
  assign cu.md_busy = 1'b0;
`endif

  assign cu.id_ready   = id_ready_s;
  assign cu.ex_valid   = valid_r;
  assign cu.RegWrite   = out_r.reg_write;
  assign cu.MemWrite   = out_r.mem_write;
  assign cu.ALUSrc     = out_r.alu_src;
  assign cu.LoadSign   = out_r.load_sign;
  assign cu.Jump       = out_r.jump;
  assign cu.JumpReg    = out_r.jump_reg;
  assign cu.Branch     = out_r.branch;
  assign cu.Illegal    = out_r.illegal;
  assign cu.ResultSrc  = out_r.result_src;
  assign cu.ImmSrc     = out_r.imm_src;
  assign cu.SizeSrc    = out_r.size_src;
  assign cu.BranchType = out_r.branch_type;
  assign cu.ALUControl = out_r.alu_control;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// -----------------------------------------------------------------------------
// tb_pipelined_control_unit
// Self-checking bench for pipelined_control_unit (MUL_CYCLES=1, DIV_CYCLES=4).
// Directed decode vectors from a table, hand-written multi-cycle sequences,
// then randomized traffic against a cycle-count based reference model.
// Expectations follow the RV32M_EN build option of the design.
// -----------------------------------------------------------------------------
module tb_pipelined_control_unit;

  localparam int MUL_N = 1;
  localparam int DIV_N = 4;
`ifdef RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  typedef struct packed {
    logic       RegWrite;
    logic       MemWrite;
    logic       ALUSrc;
    logic       LoadSign;
    logic       Jump;
    logic       JumpReg;
    logic       Branch;
    logic       Illegal;
    logic [1:0] ResultSrc;
    logic [2:0] ImmSrc;
    logic [1:0] SizeSrc;
    logic [2:0] BranchType;
    logic [4:0] ALUControl;
  } ctl_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    ctl_t       exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  pipelined_control_unit_if cu_if ();

  pipelined_control_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cu    (cu_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic ctl_t mk(input logic [7:0] bits, input logic [1:0] rs, input logic [2:0] is,
                              input logic [1:0] ss, input logic [2:0] bt, input logic [4:0] alu);
    ctl_t c;
    c = {bits, rs, is, ss, bt, alu};
    return c;
  endfunction

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c = {cu_if.RegWrite, cu_if.MemWrite, cu_if.ALUSrc, cu_if.LoadSign, cu_if.Jump,
         cu_if.JumpReg, cu_if.Branch, cu_if.Illegal, cu_if.ResultSrc, cu_if.ImmSrc,
         cu_if.SizeSrc, cu_if.BranchType, cu_if.ALUControl};
    return c;
  endfunction

  // Reference decode written from the instruction-set rules.
  function automatic ctl_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    ctl_t       c;
    logic [4:0] base [0:7];
    logic [1:0] lsz  [0:7];
    ctl_t       ill;
    base = '{5'd0, 5'd8, 5'd6, 5'd5, 5'd4, 5'd9, 5'd3, 5'd2};
    lsz  = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
    c    = '0;
    ill  = '0;
    ill.Illegal = 1'b1;
    ill.ImmSrc = 3'b111;
    ill.ALUControl = 5'd15;
    if (op == 7'b0110011) begin
      if (f7 == 7'b0000001) begin
        if (M_EN) begin
          c.RegWrite = 1'b1;
          c.ALUControl = 5'd16 + {2'b00, f3};
        end else begin
          c = ill;
        end
      end else begin
        c.RegWrite = 1'b1;
        c.ALUControl = (f7[5] && (f3 == 3'd0 || f3 == 3'd5)) ? base[f3] + 5'd1 : base[f3];
      end
    end else if (op == 7'b0010011) begin
      c.RegWrite = 1'b1;
      c.ALUSrc = 1'b1;
      c.ALUControl = (f7[5] && f3 == 3'd5) ? base[f3] + 5'd1 : base[f3];
      c.ImmSrc = (f3 == 3'd1 || f3 == 3'd5) ? 3'b101 : 3'b000;
    end else if (op == 7'b0000011) begin
      c.RegWrite = 1'b1;
      c.ALUSrc = 1'b1;
      c.ResultSrc = 2'b01;
      c.SizeSrc = lsz[f3];
      c.LoadSign = (f3 <= 3'd2);
    end else if (op == 7'b0100011) begin
      c.MemWrite = 1'b1;
      c.ALUSrc = 1'b1;
      c.ImmSrc = 3'b001;
      c.SizeSrc = (f3 == 3'd0) ? 2'b10 : ((f3 == 3'd1) ? 2'b01 : 2'b00);
    end else if (op == 7'b1100011) begin
      c.Branch = 1'b1;
      c.ImmSrc = 3'b010;
      c.BranchType = f3;
      c.ALUControl = 5'd1;
    end else if (op == 7'b1101111) begin
      c.RegWrite = 1'b1;
      c.Jump = 1'b1;
      c.ResultSrc = 2'b10;
      c.ImmSrc = 3'b011;
    end else if (op == 7'b1100111) begin
      c.RegWrite = 1'b1;
      c.JumpReg = 1'b1;
      c.ALUSrc = 1'b1;
      c.ResultSrc = 2'b10;
    end else if (op == 7'b0110111) begin
      c.RegWrite = 1'b1;
      c.ALUSrc = 1'b1;
      c.ImmSrc = 3'b100;
      c.ALUControl = 5'd7;
    end else if (op == 7'b0010111) begin
      c.RegWrite = 1'b1;
      c.ALUSrc = 1'b1;
      c.ImmSrc = 3'b100;
    end else begin
      c = ill;
    end
    return c;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkc(input string name, input ctl_t act, input ctl_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    cu_if.in_valid = v;
    cu_if.op       = op;
    cu_if.funct3   = f3;
    cu_if.funct7   = f7;
  endtask

  task automatic add_vec(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input ctl_t exp);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-phase model state: absolute edge numbers instead of a down-counter.
  bit   m_busy;
  int   m_ready_at;
  ctl_t m_pend;
  bit   m_valid;
  ctl_t m_ctl;

  initial begin
    ctl_t       div_exp;
    ctl_t       ill_exp;
    logic [6:0] ops [0:10];
    n_checks = 0;
    n_fail   = 0;
    ill_exp  = mk(8'b0000_0001, 2'b00, 3'b111, 2'b00, 3'b000, 5'b01111);
    div_exp  = mk(8'b1000_0000, 2'b00, 3'b000, 2'b00, 3'b000, 5'b10100);

    add_vec("add",   7'b0110011, 3'b000, 7'b0000000, mk(8'b1000_0000, 2'b00, 3'b000, 2'b00, 3'b000, 5'b00000));
    add_vec("sub",   7'b0110011, 3'b000, 7'b0100000, mk(8'b1000_0000, 2'b00, 3'b000, 2'b00, 3'b000, 5'b00001));
    add_vec("sll",   7'b0110011, 3'b001, 7'b0000000, mk(8'b1000_0000, 2'b00, 3'b000, 2'b00, 3'b000, 5'b01000));
    add_vec("or",    7'b0110011, 3'b110, 7'b0000000, mk(8'b1000_0000, 2'b00, 3'b000, 2'b00, 3'b000, 5'b00011));
    add_vec("lh",    7'b0000011, 3'b001, 7'b0000000, mk(8'b1011_0000, 2'b01, 3'b000, 2'b01, 3'b000, 5'b00000));
    add_vec("lbu",   7'b0000011, 3'b100, 7'b0000000, mk(8'b1010_0000, 2'b01, 3'b000, 2'b10, 3'b000, 5'b00000));
    add_vec("sb",    7'b0100011, 3'b000, 7'b0000000, mk(8'b0110_0000, 2'b00, 3'b001, 2'b10, 3'b000, 5'b00000));
    add_vec("sh",    7'b0100011, 3'b001, 7'b0000000, mk(8'b0110_0000, 2'b00, 3'b001, 2'b01, 3'b000, 5'b00000));
    add_vec("bgeu",  7'b1100011, 3'b111, 7'b0000000, mk(8'b0000_0010, 2'b00, 3'b010, 2'b00, 3'b111, 5'b00001));
    add_vec("ill",   7'b1111111, 3'b000, 7'b0000000, ill_exp);
    add_vec("srai",  7'b0010011, 3'b101, 7'b0100000, mk(8'b1010_0000, 2'b00, 3'b101, 2'b00, 3'b000, 5'b01010));
    add_vec("sltiu", 7'b0010011, 3'b011, 7'b0000000, mk(8'b1010_0000, 2'b00, 3'b000, 2'b00, 3'b000, 5'b00101));
    add_vec("lui",   7'b0110111, 3'b000, 7'b0000000, mk(8'b1010_0000, 2'b00, 3'b100, 2'b00, 3'b000, 5'b00111));
    add_vec("auipc", 7'b0010111, 3'b000, 7'b0000000, mk(8'b1010_0000, 2'b00, 3'b100, 2'b00, 3'b000, 5'b00000));
    add_vec("jal",   7'b1101111, 3'b000, 7'b0000000, mk(8'b1000_1000, 2'b10, 3'b011, 2'b00, 3'b000, 5'b00000));
    add_vec("jalr",  7'b1100111, 3'b000, 7'b0000000, mk(8'b1010_0100, 2'b10, 3'b000, 2'b00, 3'b000, 5'b00000));
`ifdef RV32M_EN
    add_vec("mul",   7'b0110011, 3'b000, 7'b0000001, mk(8'b1000_0000, 2'b00, 3'b000, 2'b00, 3'b000, 5'b10000));
`else
    add_vec("mul",   7'b0110011, 3'b000, 7'b0000001, ill_exp);
`endif

    // ---------------- reset ----------------
    rst_n = 1'b0;
    cu_if.ex_stall = 1'b0;
    cu_if.flush = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    tick();
    tick();
    chk1("rst_ex_valid", cu_if.ex_valid, 1'b0);
    chk1("rst_md_busy", cu_if.md_busy, 1'b0);
    chk1("rst_id_ready", cu_if.id_ready, 1'b1);
    chkc("rst_ctl", dut_ctl(), '0);
    cu_if.ex_stall = 1'b1;
    #1;
    chk1("rst_id_ready_stall", cu_if.id_ready, 1'b0);
    cu_if.ex_stall = 1'b0;
    rst_n = 1'b1;

    // ---------------- decode table, back-to-back ----------------
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f7);
      tick();
      chk1({vecs[i].name, "_valid"}, cu_if.ex_valid, 1'b1);
      chkc({vecs[i].name, "_ctl"}, dut_ctl(), vecs[i].exp);
    end

    // ---------------- hold under ex_stall, then bubble ----------------
    drive(1'b1, 7'b0110011, 3'b000, 7'b0000000);
    tick();
    cu_if.ex_stall = 1'b1;
    drive(1'b1, 7'b0110011, 3'b000, 7'b0100000);
    #1;
    chk1("stall_id_ready", cu_if.id_ready, 1'b0);
    tick();
    chk1("stall_hold_valid", cu_if.ex_valid, 1'b1);
    chkc("stall_hold_ctl", dut_ctl(), vecs[0].exp);
    cu_if.ex_stall = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 7'd0);
    tick();
    chk1("bubble_valid", cu_if.ex_valid, 1'b0);

    // ---------------- DIV latency ----------------
    drive(1'b1, 7'b0110011, 3'b100, 7'b0000001);
    #1;
    chk1("div_accept_ready", cu_if.id_ready, 1'b1);
    tick();
    cu_if.in_valid = 1'b0;
`ifdef RV32M_EN
    for (int i = 0; i < DIV_N; i++) begin
      chk1("div_wait_busy", cu_if.md_busy, 1'b1);
      chk1("div_wait_ready", cu_if.id_ready, 1'b0);
      chk1("div_wait_valid", cu_if.ex_valid, 1'b0);
      if (i < DIV_N - 1) tick();
    end
    tick();
    chk1("div_done_valid", cu_if.ex_valid, 1'b1);
    chkc("div_done_ctl", dut_ctl(), div_exp);
    chk1("div_done_busy", cu_if.md_busy, 1'b0);
    chk1("div_done_ready", cu_if.id_ready, 1'b1);

    // DIV with ex_stall while the counter sits at zero
    drive(1'b1, 7'b0110011, 3'b100, 7'b0000001);
    tick();
    cu_if.in_valid = 1'b0;
    repeat (DIV_N - 1) tick();
    cu_if.ex_stall = 1'b1;
    tick();
    chk1("divst_valid_a", cu_if.ex_valid, 1'b0);
    chk1("divst_busy_a", cu_if.md_busy, 1'b1);
    tick();
    chk1("divst_valid_b", cu_if.ex_valid, 1'b0);
    cu_if.ex_stall = 1'b0;
    tick();
    chk1("divst_valid_c", cu_if.ex_valid, 1'b1);
    chkc("divst_ctl", dut_ctl(), div_exp);

    // flush during WAIT
    drive(1'b1, 7'b0110011, 3'b100, 7'b0000001);
    tick();
    cu_if.in_valid = 1'b0;
    tick();
    cu_if.flush = 1'b1;
    #1;
    chk1("flush_id_ready", cu_if.id_ready, 1'b0);
    tick();
    cu_if.flush = 1'b0;
    chk1("flush_valid", cu_if.ex_valid, 1'b0);
    chk1("flush_busy", cu_if.md_busy, 1'b0);
    #1;
    chk1("flush_ready_after", cu_if.id_ready, 1'b1);
    repeat (DIV_N + 1) tick();
    chk1("flush_no_late_release", cu_if.ex_valid, 1'b0);

    // reset in the middle of WAIT
    drive(1'b1, 7'b0110011, 3'b100, 7'b0000001);
    tick();
    cu_if.in_valid = 1'b0;
    chk1("rstwait_busy_before", cu_if.md_busy, 1'b1);
`else
    chk1("nom_div_valid", cu_if.ex_valid, 1'b1);
    chkc("nom_div_ctl", dut_ctl(), ill_exp);
    chk1("nom_div_busy", cu_if.md_busy, 1'b0);
    chk1("nom_div_ready", cu_if.id_ready, 1'b1);
`endif
    rst_n = 1'b0;
    #1;
    chk1("rst_async_busy", cu_if.md_busy, 1'b0);
    chk1("rst_async_valid", cu_if.ex_valid, 1'b0);
    chk1("rst_async_ready", cu_if.id_ready, 1'b1);
    #1;
    rst_n = 1'b1;
    tick();

    // ---------------- randomized traffic vs model ----------------
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0110011};
    m_busy = 1'b0; m_ready_at = 0; m_pend = '0; m_valid = 1'b0; m_ctl = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic       exp_ready;
      logic [6:0] rop;
      logic [6:0] rf7;
      logic [2:0] rf3;
      ctl_t       d;
      int         n;
      int         sel;
      sel = $urandom_range(0, 11);
      if (sel == 11) begin
        rop = 7'($urandom);
      end else begin
        rop = ops[sel];
      end
      rf3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0:       rf7 = 7'b0000000;
        1:       rf7 = 7'b0100000;
        2:       rf7 = 7'b0000001;
        default: rf7 = 7'($urandom);
      endcase
      drive(($urandom_range(0, 9) < 7), rop, rf3, rf7);
      cu_if.ex_stall = ($urandom_range(0, 3) == 0);
      cu_if.flush    = ($urandom_range(0, 19) == 0);
      #1;
      exp_ready = !cu_if.flush && !m_busy && !cu_if.ex_stall;
      chk1("rnd_id_ready", cu_if.id_ready, exp_ready);

      d = ref_decode(rop, rf3, rf7);
      n = (M_EN && rop == 7'b0110011 && rf7 == 7'b0000001) ? (rf3[2] ? DIV_N : MUL_N) : 1;
      if (cu_if.flush) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
      end else if (m_busy) begin
        if (cyc >= m_ready_at && !cu_if.ex_stall) begin
          m_valid = 1'b1;
          m_ctl   = m_pend;
          m_busy  = 1'b0;
        end
      end else if (cu_if.ex_stall) begin
        m_valid = m_valid;
      end else if (cu_if.in_valid) begin
        if (n > 1) begin
          m_busy     = 1'b1;
          m_ready_at = cyc + n;
          m_pend     = d;
          m_valid    = 1'b0;
        end else begin
          m_valid = 1'b1;
          m_ctl   = d;
        end
      end else begin
        m_valid = 1'b0;
      end

      @(posedge clk);
      #1;
      chk1("rnd_ex_valid", cu_if.ex_valid, m_valid);
      chk1("rnd_md_busy", cu_if.md_busy, m_busy);
      if (m_valid) chkc("rnd_ctl", dut_ctl(), m_ctl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
